// File: rtl/rr_queue_sched.sv
// rr_queue_sched: round-robin arbiter that feeds one bounded circular queue
// shared by NUM_REQ requesters, drained through a valid/ready output port.
//
// Each cycle at most one requester is granted, searching upward from rr_ptr.
// A pop frees a slot in the same cycle, so a full queue can still accept a
// word while it is draining.
//
// Optional build macro: RR_QUEUE_SCHED_STATS_EN adds the grant_total and
// drop_cycles statistics outputs.
module rr_queue_sched #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]     req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         out_valid,
    output logic [WIDTH-1:0]             out_data,
    output logic [$clog2(NUM_REQ)-1:0]   out_src,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
`ifdef RR_QUEUE_SCHED_STATS_EN
    ,
    output logic [31:0]                  grant_total,
    output logic [31:0]                  drop_cycles
`endif
);

    localparam int SRC_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [SRC_W:0]   NREQ_EXT = (SRC_W + 1)'(NUM_REQ);
    localparam logic [SRC_W-1:0] LAST_REQ = SRC_W'(NUM_REQ - 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);

    // Storage and pointers
    logic [WIDTH-1:0] mem_data [DEPTH];
    logic [SRC_W-1:0] mem_src  [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_r;
    logic [SRC_W-1:0] rr_ptr;

    // Arbitration results
    logic             found;
    logic [SRC_W-1:0] grant_idx;
    logic [SRC_W:0]   cand;
    logic [WIDTH-1:0] grant_data;

    // Handshake terms
    logic full_i;
    logic pop;
    logic space;
    logic push;

    // Status outputs are forced to their reset values while rst is high so the
    // consumer never sees stale entries during the reset cycle.
    always_comb begin
        count     = rst ? '0 : count_r;
        full_i    = !rst && (count_r == DEPTH_C);
        full      = full_i;
        empty     = rst || (count_r == '0);
        out_valid = !rst && (count_r != '0);
        out_data  = rst ? '0 : mem_data[rd_ptr];
        out_src   = rst ? '0 : mem_src[rd_ptr];
    end

    assign pop   = out_valid && out_ready;
    assign space = !full_i || pop;

    // Round-robin search: first valid requester at or above rr_ptr, wrapping.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr} + (SRC_W + 1)'(k);
            if (cand >= NREQ_EXT) begin
                cand = cand - NREQ_EXT;
            end
            if (!found && req_valid[cand[SRC_W-1:0]]) begin
                found     = 1'b1;
                grant_idx = cand[SRC_W-1:0];
            end
        end
    end

    assign push       = found && space && !rst;
    assign grant_data = req_data[grant_idx*WIDTH +: WIDTH];

    // One-hot grant; zero when there is no room or no requester.
    always_comb begin
        req_ready = '0;
        if (push) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Queue storage write on push; cleared on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_src[i]  <= '0;
            end
        end else if (push) begin
            mem_data[wr_ptr] <= grant_data;
            mem_src[wr_ptr]  <= grant_idx;
        end
    end

    // Pointer, occupancy and round-robin pointer update.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_r <= '0;
            rr_ptr  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
                rr_ptr <= (grant_idx == LAST_REQ) ? '0 : grant_idx + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count_r <= count_r + 1'b1;
            end else if (pop && !push) begin
                count_r <= count_r - 1'b1;
            end
        end
    end

`ifdef RR_QUEUE_SCHED_STATS_EN
    // Statistics: grants wrap, stall cycles saturate.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_total <= '0;
            drop_cycles <= '0;
        end else begin
            if (push) begin
                grant_total <= grant_total + 32'd1;
            end
            if ((|req_valid) && !space && (drop_cycles != 32'hFFFF_FFFF)) begin
                drop_cycles <= drop_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rr_queue_sched.sv
// Self-checking bench for rr_queue_sched (default parameters NUM_REQ=4,
// WIDTH=8, DEPTH=4). A queue-based reference model predicts every output.
// Build with RR_QUEUE_SCHED_STATS_EN to also check the statistics counters.
module tb_rr_queue_sched;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 8;
    localparam int DEPTH   = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_src;
    logic        out_ready = 1'b0;
    logic [2:0]  count;
    logic        full;
    logic        empty;
`ifdef RR_QUEUE_SCHED_STATS_EN
    logic [31:0] grant_total;
    logic [31:0] drop_cycles;
`endif

    rr_queue_sched #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_ready(req_ready),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_src(out_src),
        .out_ready(out_ready),
        .count(count),
        .full(full),
        .empty(empty)
`ifdef RR_QUEUE_SCHED_STATS_EN
        ,
        .grant_total(grant_total),
        .drop_cycles(drop_cycles)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: FIFO of {src, data}, round-robin start index, stats.
    logic [9:0]  mq[$];
    int          rr = 0;
    int          last_grant = -1;
    longint      m_grants = 0;
    longint      m_drops = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at negedge, check predicted outputs, advance model.
    task automatic cycle(input logic [3:0] v, input logic [31:0] d, input logic o);
        bit        exp_valid;
        bit        pop;
        bit        space;
        int        g;
        logic [3:0] exp_ready;
        @(negedge clk);
        req_valid = v;
        req_data  = d;
        out_ready = o;
        #1;
        exp_valid = (mq.size() != 0);
        pop       = exp_valid && o;
        space     = (mq.size() < DEPTH) || pop;
        g = -1;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (g < 0 && v[(rr + k) % NUM_REQ]) g = (rr + k) % NUM_REQ;
        end
        exp_ready = (space && g >= 0) ? (4'b0001 << g) : 4'b0000;
        check("req_ready", {28'd0, req_ready}, {28'd0, exp_ready});
        check("out_valid", {31'd0, out_valid}, {31'd0, exp_valid});
        if (exp_valid) begin
            check("out_data", {24'd0, out_data}, {24'd0, mq[0][7:0]});
            check("out_src", {30'd0, out_src}, {30'd0, mq[0][9:8]});
        end
        check("count", {29'd0, count}, mq.size());
        check("full", {31'd0, full}, {31'd0, mq.size() == DEPTH});
        check("empty", {31'd0, empty}, {31'd0, mq.size() == 0});
        check("count_bound", {31'd0, count <= DEPTH}, 32'd1);
`ifdef RR_QUEUE_SCHED_STATS_EN
        check("grant_total", grant_total, m_grants[31:0]);
        check("drop_cycles", drop_cycles, m_drops[31:0]);
`endif
        if (v != 4'b0000 && !space && m_drops < 64'hFFFF_FFFF) m_drops++;
        if (pop) void'(mq.pop_front());
        last_grant = -1;
        if (space && g >= 0) begin
            logic [7:0] w;
            w = d[g*8 +: 8];
            mq.push_back({g[1:0], w});
            rr = (g + 1) % NUM_REQ;
            last_grant = g;
            m_grants++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        req_valid = 4'b1111;
        out_ready = 1'b1;
        #1;
        check("rst_req_ready", {28'd0, req_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_empty", {31'd0, empty}, 32'd1);
        check("rst_full", {31'd0, full}, 32'd0);
        check("rst_out_data", {24'd0, out_data}, 32'd0);
        check("rst_out_src", {30'd0, out_src}, 32'd0);
        @(negedge clk);
        rst       = 1'b0;
        req_valid = 4'b0000;
        mq.delete();
        rr       = 0;
        m_grants = 0;
        m_drops  = 0;
    endtask

    initial begin
        // Test 1: reset and idle, then reset mid-stream with three queued.
        rst = 1'b1;
        @(negedge clk);
        do_reset();
        cycle(4'b0000, 32'd0, 1'b1);
        check("t1_idle_count", {29'd0, count}, 32'd0);
        check("t1_idle_ready", {28'd0, req_ready}, 32'd0);
        for (int i = 0; i < 3; i++) cycle(4'b1111, $urandom, 1'b0);
        cycle(4'b0000, 32'd0, 1'b0);
        check("t1_count3", {29'd0, count}, 32'd3);
        do_reset();
        cycle(4'b0000, 32'd0, 1'b0);
        check("t1_after_rst_count", {29'd0, count}, 32'd0);
        check("t1_after_rst_valid", {31'd0, out_valid}, 32'd0);

        // Test 2: single requester 2 with data A5.
        cycle(4'b0100, 32'h00A5_0000, 1'b1);
        check("t2_ready", {28'd0, req_ready}, 32'h4);
        cycle(4'b0000, 32'd0, 1'b1);
        check("t2_out_valid", {31'd0, out_valid}, 32'd1);
        check("t2_out_data", {24'd0, out_data}, 32'hA5);
        check("t2_out_src", {30'd0, out_src}, 32'd2);
        cycle(4'b0000, 32'd0, 1'b1);
        check("t2_empty", {31'd0, empty}, 32'd1);

        // Test 3: all valid, no backpressure: grants rotate 0,1,2,3,...
        do_reset();
        for (int k = 0; k < 8; k++) begin
            cycle(4'b1111, $urandom, 1'b1);
            check("t3_rr_order", {28'd0, req_ready}, 32'd1 << (k % 4));
        end

        // Test 4: fill to full, stall, then push+pop in the same cycle.
        do_reset();
        for (int k = 0; k < 4; k++) cycle(4'b1111, $urandom, 1'b0);
        cycle(4'b1111, $urandom, 1'b0);
        check("t4_full", {31'd0, full}, 32'd1);
        check("t4_count", {29'd0, count}, 32'd4);
        check("t4_stall_ready", {28'd0, req_ready}, 32'd0);
        cycle(4'b1111, $urandom, 1'b1);
        check("t4_resume_ready", {28'd0, req_ready}, 32'd1);
        cycle(4'b1111, $urandom, 1'b1);
        check("t4_count_held", {29'd0, count}, 32'd4);

        // Test 5: ten push/pop pairs on a full queue with unique words.
        for (int k = 0; k < 10; k++) begin
            int r;
            logic [31:0] d;
            r = $urandom_range(0, 3);
            d = '0;
            d[r*8 +: 8] = 8'(8'h40 + k);
            cycle(4'b0001 << r, d, 1'b1);
            check("t5_count", {29'd0, count}, 32'd4);
        end
        for (int k = 0; k < 5; k++) cycle(4'b0000, 32'd0, 1'b1);
        check("t5_drained", {31'd0, empty}, 32'd1);

`ifdef RR_QUEUE_SCHED_STATS_EN
        // Test 6: 5 pushes and 3 full-stall cycles with requests pending.
        do_reset();
        for (int k = 0; k < 4; k++) cycle(4'b1111, $urandom, 1'b0);
        for (int k = 0; k < 3; k++) cycle(4'b1111, $urandom, 1'b0);
        cycle(4'b1111, $urandom, 1'b1);
        cycle(4'b0000, 32'd0, 1'b0);
        check("t6_grant_total", grant_total, 32'd5);
        check("t6_drop_cycles", drop_cycles, 32'd3);
`endif

        // Random traffic against the model, with occasional resets.
        do_reset();
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                cycle(4'($urandom_range(0, 15)), $urandom, $urandom_range(0, 3) != 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
